// File: rtl/fiqsha_apb_adapter.sv
// APB slave front end for the FIQSHA hash core: posted-write FIFO toward the native
// register bus, reads held until the FIFO drains, plus overflow and burst hints.
module fiqsha_apb_adapter #(
    parameter int FIQSHA_BUS_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH            = 4,
    parameter int MAX_WAIT              = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             psel_i,
    input  logic                             penable_i,
    input  logic                             pwrite_i,
    input  logic [11:0]                      paddr_i,
    input  logic [FIQSHA_BUS_DATA_WIDTH-1:0] pwdata_i,
    output logic [FIQSHA_BUS_DATA_WIDTH-1:0] prdata_o,
    output logic                             pready_o,
    output logic                             pslverr_o,
    output logic                             wr_o,
    input  logic                             wr_ack_i,
    output logic [11:0]                      waddr_o,
    output logic [FIQSHA_BUS_DATA_WIDTH-1:0] wdata_o,
    output logic                             rd_o,
    output logic [11:0]                      raddr_o,
    input  logic [FIQSHA_BUS_DATA_WIDTH-1:0] rdata_i,
    input  logic                             read_valid_i,
    output logic                             rd_ack_o,
    output logic [1:0]                       burst_type_o,
    output logic                             overflow_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] C_DEPTH     = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_ONE       = CW'(1);
    localparam logic [WW-1:0] C_WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [11:0]   C_STRIDE    = 12'(FIQSHA_BUS_DATA_WIDTH / 8);

    logic [11:0]                      r_mem_addr [FIFO_DEPTH];
    logic [FIQSHA_BUS_DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [PW-1:0]                    r_wptr;
    logic [PW-1:0]                    r_rptr;
    logic [CW-1:0]                    r_count;
    logic [WW-1:0]                    r_wait;
    logic [11:0]                      r_last_addr;
    logic                             r_last_valid;

    logic                             w_empty;
    logic                             w_full;
    logic                             w_wr_acc;
    logic                             w_rd_acc;
    logic                             w_timeout;
    logic                             w_push;
    logic                             w_pop;
    logic                             w_rd_go;
    logic [11:0]                      w_head_addr;
    logic [FIQSHA_BUS_DATA_WIDTH-1:0] w_head_data;

    // Access decode and all bus-facing outputs; every term is gated by reset.
    always_comb begin
        w_empty     = (r_count == '0);
        w_full      = (r_count == C_DEPTH);
        w_wr_acc    = psel_i & penable_i & pwrite_i & ~rst_i;
        w_rd_acc    = psel_i & penable_i & ~pwrite_i & ~rst_i;
        w_timeout   = w_wr_acc & w_full & (r_wait == C_WAIT_LAST);
        w_push      = w_wr_acc & ~w_full;
        w_pop       = ~w_empty & wr_ack_i & ~rst_i;
        w_rd_go     = w_rd_acc & w_empty;
        w_head_addr = r_mem_addr[r_rptr];
        w_head_data = r_mem_data[r_rptr];

        pready_o     = w_push | w_timeout | w_rd_go;
        pslverr_o    = w_timeout | (w_rd_go & ~read_valid_i);
        overflow_o   = w_timeout;
        rd_o         = w_rd_go;
        rd_ack_o     = w_rd_go;
        raddr_o      = rst_i ? 12'h000 : paddr_i;
        prdata_o     = (w_rd_go & read_valid_i) ? rdata_i : '0;
        wr_o         = ~w_empty & ~rst_i;
        waddr_o      = 12'h000;
        wdata_o      = '0;
        burst_type_o = 2'b00;

        if (wr_o) begin
            waddr_o = w_head_addr;
            wdata_o = w_head_data;
            // Burst hint compares the head against the address most recently handed off.
            if (r_last_valid && (w_head_addr == r_last_addr)) begin
                burst_type_o = 2'b10;
            end else if (r_last_valid && (w_head_addr == r_last_addr + C_STRIDE)) begin
                burst_type_o = 2'b01;
            end else begin
                burst_type_o = 2'b00;
            end
        end else begin
            burst_type_o = 2'b00;
        end
    end

    // FIFO storage; contents need no reset because count gates their visibility.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= paddr_i;
            r_mem_data[r_wptr] <= pwdata_i;
        end
    end

    // Pointers, occupancy, stall counter and last-popped address tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_wait       <= '0;
            r_last_addr  <= 12'h000;
            r_last_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
            // Stall counter only advances while a write waits on a full FIFO.
            r_wait <= (w_wr_acc & w_full & ~w_timeout) ? r_wait + WW'(1) : '0;
            if (w_pop) begin
                r_last_addr  <= w_head_addr;
                r_last_valid <= ~((r_count == C_ONE) & ~w_push);
            end else if (w_empty && !w_push) begin
                r_last_valid <= 1'b0;
            end
        end
    end

endmodule
